// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle processor control FSM
//
// Purpose: Moore-style control unit for a multi-cycle datapath. State
// decodes all datapath controls; pc_en, ir_write and illegal also depend
// on the current inputs (mem_ready, zero, opcode/funct).
//
// Configuration macro: MC_BNE_EN - when defined, opcode 1001 (BNE) is
// decoded to BRANCH with a latched bne flag that inverts the branch test.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   opcode[3:0], funct[2:0] instruction fields held in the IR
//   zero                   ALU zero flag
//   mem_ready              memory done strobe (FETCH, MEMRD, MEMWR)
//   pc_en, iord            PC load enable, memory address select
//   mem_read, mem_write    memory strobes
//   ir_write               IR load enable
//   reg_write, reg_dst, mem_to_reg  register-file controls
//   alu_src_a, alu_src_b[1:0], alu_op[3:0]  ALU operand/op selects
//   pc_source[1:0]         PC mux select
//   state[3:0]             current state code (debug)
//   illegal                one-cycle pulse on an undefined instruction
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b0111;
  localparam logic [3:0] OP_J     = 4'b1000;
`ifdef MC_BNE_EN
  localparam logic [3:0] OP_BNE   = 4'b1001;
`endif

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] decode_next;
  logic       decode_illegal;
  logic       funct_ok;
  logic       bne_q;

  // Instruction decode used by DECODE; an undefined encoding returns to
  // FETCH so no write state is ever entered.
  always_comb begin
    funct_ok       = (funct == 3'b000) || (funct == 3'b001) || (funct == 3'b010) ||
                     (funct == 3'b110) || (funct == 3'b111);
    decode_next    = S_FETCH;
    decode_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct_ok) decode_next = S_EXEC;
        else          decode_illegal = 1'b1;
      end
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_BEQ:       decode_next = S_BRANCH;
      OP_ADDI:      decode_next = S_ADDIEX;
      OP_J:         decode_next = S_JUMP;
`ifdef MC_BNE_EN
      OP_BNE:       decode_next = S_BRANCH;
`endif
      default:      decode_illegal = 1'b1;
    endcase
  end

`ifdef MC_BNE_EN
  // BEQ and BNE share the BRANCH state; the flag remembers which one it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bne_q <= 1'b0;
    else if (state_q == S_DECODE)
      bne_q <= (opcode == OP_BNE);
  end
`else
  assign bne_q = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_next;
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 4'b0000;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        illegal   = decode_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          3'b000:  alu_op = ALU_AND;
          3'b001:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_ADD;
          3'b110:  alu_op = ALU_SUB;
          3'b111:  alu_op = ALU_SLT;
          default: alu_op = ALU_AND;
        endcase
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 2'b01;
        pc_en     = zero ^ bne_q;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_en     = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
    // Reset drops the state to FETCH asynchronously; the input-dependent
    // enables must also be killed without waiting for a clock.
    if (!rst_n) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state = state_q;

endmodule
